caf_peak_search: RTL and testbench
==================================

CAF_PEAK_SEARCH -- requirements
Module: caf_peak_search

Interface
REQ-001 SHALL have parameter phase_bits, default 10, width of freq_step and step_size.
REQ-002 SHALL have parameter out_max_bits, default 5, width of the incoming slice peak magnitude.
REQ-003 SHALL have parameter length_counter_bits, default 3, width of the incoming lag index.
REQ-004 SHALL have parameter freq_bins, default 8, the number of frequency bins per sweep (2 or more).
REQ-005 SHALL have parameter freq_bin_bits, default 3, width of the bin counter, with 2^freq_bin_bits >= freq_bins.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk, input, 1 bit: the single clock; all state changes on its rising edge.
- rst_n, input, 1 bit: asynchronous active-low reset.
- start, input, 1 bit: sweep request; sampled only in IDLE.
- step_size, input, phase_bits: per-bin frequency increment.
- freq_step, output, phase_bits: frequency step for the current bin, driven to the slice.
- freq_step_valid, output, 1 bit: one-cycle pulse when freq_step changes.
- m_axis_tvalid, input, 1 bit: slice result valid.
- out_max, input, out_max_bits: slice peak magnitude.
- index, input, length_counter_bits: slice peak lag.
- s_axis_tready, output, 1 bit: ready to accept a slice result.
- peak_max, output, out_max_bits: global peak magnitude.
- peak_index, output, length_counter_bits: lag of the global peak.
- peak_bin, output, freq_bin_bits: frequency bin of the global peak.
- s_axis_tvalid, output, 1 bit: sweep result valid.
- m_axis_tready, input, 1 bit: downstream accepts the result.
- busy, output, 1 bit: high in COLLECT and DONE.

Function
REQ-007 SHALL implement the FSM states IDLE, COLLECT and DONE.
REQ-008 SHALL, in IDLE with start=1, clear bin to 0, load freq_step with 0, pulse freq_step_valid in the next cycle, and enter COLLECT.
REQ-009 SHALL drive s_axis_tready=1 only in COLLECT; a result is accepted on a cycle with m_axis_tvalid=1 and s_axis_tready=1.
REQ-010 SHALL, on the accept for bin 0, load peak_max, peak_index and peak_bin unconditionally.
REQ-011 SHALL, on an accept for bin>0, load the peak registers only if out_max > peak_max (unsigned, strict), so the earliest bin wins a tie.
REQ-012 SHALL, on an accept with bin < freq_bins-1, increment bin, set freq_step to freq_step+step_size (modulo 2^phase_bits, accumulator, no multiplier), and pulse freq_step_valid in the next cycle.
REQ-013 SHALL, on an accept with bin == freq_bins-1, enter DONE with no freq_step_valid pulse and freq_step held.
REQ-014 SHALL, in DONE, drive s_axis_tvalid=1 and hold peak_max, peak_index and peak_bin stable until m_axis_tready=1, then return to IDLE in the next cycle.
REQ-015 SHALL ignore start outside IDLE.
REQ-016 SHALL ignore m_axis_tvalid outside COLLECT.
REQ-017 SHALL, when start=1 arrives in IDLE on the same cycle DONE exits, not launch a sweep; start is honoured only once the block is in IDLE.
REQ-018 SHALL have a latency of 1 cycle from the final accept to s_axis_tvalid=1.
REQ-019 SHALL assert freq_step_valid for exactly 1 cycle per bin, freq_bins pulses per sweep.
REQ-020 SHALL retain the peak outputs from a completed sweep in IDLE until the next start, which clears them on the bin-0 accept.

Reset
REQ-021 SHALL, on rst_n=0, asynchronously force IDLE, with bin, freq_step, peak_max, peak_index and peak_bin at 0, and freq_step_valid, s_axis_tready, s_axis_tvalid and busy at 0.
REQ-022 SHALL, on reset mid-sweep, abandon the sweep with no s_axis_tvalid, and require a new start after rst_n returns high.

Structure
REQ-023 SHALL take its state encodings (IDLE=0, COLLECT=1, DONE=2) as localparams from the shared package caf_pkg, which also holds the common CAF width defaults.
REQ-024 SHALL be a single flat module with no sub-module; the step accumulator and peak compare are inline.

Verification
REQ-025 SHALL verify, with freq_bins=4, step_size=5 and out_max inputs 3,9,9,2: peak_max=9, peak_bin=1, freq_step sequence 0,5,10,15, and 4 freq_step_valid pulses.
REQ-026 SHALL verify that out_max 0,0,0,0 yields peak_max=0, peak_bin=0, peak_index equal to the bin-0 index, and s_axis_tvalid 1 cycle after the 4th accept.
REQ-027 SHALL verify, with m_axis_tready held low 10 cycles in DONE, that the outputs stay stable, s_axis_tvalid stays 1, and start pulses are ignored; IDLE follows 1 cycle after ready.
REQ-028 SHALL verify that step_size=1000 with phase_bits=10 gives freq_step 0,1000,976,952 (wrap modulo 1024).
REQ-029 SHALL verify that rst_n pulsed low after the 2nd accept clears all outputs immediately, that a subsequent m_axis_tvalid is ignored, and that a new start runs a clean sweep.
REQ-030 SHALL verify that m_axis_tvalid asserted in IDLE before start is not accepted (s_axis_tready=0) and does not alter the peak registers.

Source files
------------

// File: rtl/caf_pkg.sv
// Shared CAF definitions: sweep FSM state encodings and common width defaults.
package caf_pkg;

  // Sweep FSM state encodings (legacy-compatible numeric values).
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Common CAF width defaults.
  localparam int unsigned PHASE_BITS_DEF          = 10;
  localparam int unsigned OUT_MAX_BITS_DEF        = 5;
  localparam int unsigned LENGTH_COUNTER_BITS_DEF = 3;
  localparam int unsigned FREQ_BINS_DEF           = 8;
  localparam int unsigned FREQ_BIN_BITS_DEF       = 3;

endpackage

// File: rtl/caf_peak_search.sv
// Frequency sweep controller for the cross-ambiguity function. Steps the
// slice through freq_bins frequency offsets, collects one peak per bin and
// reports the global peak (magnitude, lag, bin) once the sweep completes.
module caf_peak_search
  import caf_pkg::*;
#(
  parameter int unsigned phase_bits          = PHASE_BITS_DEF,
  parameter int unsigned out_max_bits        = OUT_MAX_BITS_DEF,
  parameter int unsigned length_counter_bits = LENGTH_COUNTER_BITS_DEF,
  parameter int unsigned freq_bins           = FREQ_BINS_DEF,
  parameter int unsigned freq_bin_bits       = FREQ_BIN_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [phase_bits-1:0]          step_size,
  output logic [phase_bits-1:0]          freq_step,
  output logic                           freq_step_valid,
  input  logic                           m_axis_tvalid,
  input  logic [out_max_bits-1:0]        out_max,
  input  logic [length_counter_bits-1:0] index,
  output logic                           s_axis_tready,
  output logic [out_max_bits-1:0]        peak_max,
  output logic [length_counter_bits-1:0] peak_index,
  output logic [freq_bin_bits-1:0]       peak_bin,
  output logic                           s_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           busy
);

  localparam logic [freq_bin_bits-1:0] LAST_BIN = freq_bin_bits'(freq_bins - 1);

  logic [1:0]               state;
  logic [freq_bin_bits-1:0] bin;
  logic                     accept;
  logic                     take_peak;

  // Handshake and status decode straight from the state register.
  always_comb begin
    s_axis_tready = (state == COLLECT);
    s_axis_tvalid = (state == DONE);
    busy          = (state != IDLE);
    accept        = s_axis_tready && m_axis_tvalid;
    // Bin 0 seeds the peak; later bins replace it only on a strictly larger
    // magnitude, so the earliest bin wins a tie.
    take_peak     = (bin == '0) || (out_max > peak_max);
  end

  // Sweep FSM, frequency step accumulator and running peak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bin             <= '0;
      freq_step       <= '0;
      freq_step_valid <= 1'b0;
      peak_max        <= '0;
      peak_index      <= '0;
      peak_bin        <= '0;
    end else begin
      freq_step_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin             <= '0;
            freq_step       <= '0;
            freq_step_valid <= 1'b1;
            state           <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (take_peak) begin
              peak_max   <= out_max;
              peak_index <= index;
              peak_bin   <= bin;
            end
            if (bin != LAST_BIN) begin
              bin             <= bin + 1'b1;
              freq_step       <= freq_step + step_size;
              freq_step_valid <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (m_axis_tready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caf_peak_search.sv
// Directed self-checking bench for caf_peak_search with a 4-bin sweep.
module tb_caf_peak_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] step_size = '0;
  logic [9:0] freq_step;
  logic       freq_step_valid;
  logic       m_axis_tvalid = 1'b0;
  logic [4:0] out_max = '0;
  logic [2:0] index = '0;
  logic       s_axis_tready;
  logic [4:0] peak_max;
  logic [2:0] peak_index;
  logic [1:0] peak_bin;
  logic       s_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  logic [4:0] vals [4];
  logic [2:0] idxs [4];
  logic [9:0] exp_fs [4];

  caf_peak_search #(
    .phase_bits(10),
    .out_max_bits(5),
    .length_counter_bits(3),
    .freq_bins(4),
    .freq_bin_bits(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .step_size(step_size),
    .freq_step(freq_step),
    .freq_step_valid(freq_step_valid),
    .m_axis_tvalid(m_axis_tvalid),
    .out_max(out_max),
    .index(index),
    .s_axis_tready(s_axis_tready),
    .peak_max(peak_max),
    .peak_index(peak_index),
    .peak_bin(peak_bin),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Count freq_step_valid pulses, sampled away from the active edge.
  always @(negedge clk) if (freq_step_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_peak(input string tag, input logic [4:0] m, input logic [2:0] i, input logic [1:0] b);
    chk({tag, "_max"}, 32'(peak_max), 32'(m));
    chk({tag, "_idx"}, 32'(peak_index), 32'(i));
    chk({tag, "_bin"}, 32'(peak_bin), 32'(b));
  endtask

  // Start a sweep and feed the four bins; leaves the DUT in DONE.
  task automatic sweep(input string tag, input logic [9:0] step);
    step_size = step;
    pulses = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_fsv"}, 32'(freq_step_valid), 32'd1);
      chk({tag, "_fs"}, 32'(freq_step), 32'(exp_fs[k]));
      chk({tag, "_rdy"}, 32'(s_axis_tready), 32'd1);
      m_axis_tvalid = 1'b1;
      out_max = vals[k];
      index = idxs[k];
      tick();
      m_axis_tvalid = 1'b0;
    end
    chk({tag, "_tvalid_lat"}, 32'(s_axis_tvalid), 32'd1);
    chk({tag, "_fsv_last"}, 32'(freq_step_valid), 32'd0);
    chk({tag, "_fs_hold"}, 32'(freq_step), 32'(exp_fs[3]));
    chk({tag, "_pulses"}, 32'(pulses), 32'd4);
  endtask

  task automatic release_done(input string tag);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_tvalid"}, 32'(s_axis_tvalid), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tvalid", 32'(s_axis_tvalid), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_fsv", 32'(freq_step_valid), 32'd0);
    chk("rst_fs", 32'(freq_step), 32'd0);
    check_peak("rst", 5'd0, 3'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic sweep: tie at 9 resolves to the earlier bin.
    vals = '{5'd3, 5'd9, 5'd9, 5'd2};
    idxs = '{3'd1, 3'd2, 3'd3, 3'd4};
    exp_fs = '{10'd0, 10'd5, 10'd10, 10'd15};
    sweep("basic", 10'd5);
    check_peak("basic", 5'd9, 3'd2, 2'd1);
    release_done("basic");

    // IDLE: stray m_axis_tvalid is not accepted and peaks are retained.
    m_axis_tvalid = 1'b1;
    out_max = 5'd31;
    index = 3'd7;
    #1;
    chk("idle_tready", 32'(s_axis_tready), 32'd0);
    tick();
    tick();
    m_axis_tvalid = 1'b0;
    check_peak("idle_hold", 5'd9, 3'd2, 2'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // All-zero magnitudes: bin 0 wins with its own index.
    vals = '{5'd0, 5'd0, 5'd0, 5'd0};
    idxs = '{3'd5, 3'd6, 3'd7, 3'd0};
    exp_fs = '{10'd0, 10'd5, 10'd10, 10'd15};
    sweep("zero", 10'd5);
    check_peak("zero", 5'd0, 3'd5, 2'd0);
    release_done("zero");

    // Backpressure in DONE with start pulses that must be ignored.
    vals = '{5'd4, 5'd17, 5'd30, 5'd30};
    idxs = '{3'd0, 3'd7, 3'd3, 3'd1};
    exp_fs = '{10'd0, 10'd7, 10'd14, 10'd21};
    sweep("hold", 10'd7);
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      tick();
      chk("hold_tvalid", 32'(s_axis_tvalid), 32'd1);
      chk("hold_fsv", 32'(freq_step_valid), 32'd0);
      check_peak("hold", 5'd30, 3'd3, 2'd2);
    end
    // start coincident with the DONE exit must not launch a sweep.
    start = 1'b1;
    release_done("hold");
    start = 1'b0;
    tick();
    chk("exit_start_busy", 32'(busy), 32'd0);
    chk("exit_start_fsv", 32'(freq_step_valid), 32'd0);

    // Phase accumulator wrap modulo 1024.
    vals = '{5'd1, 5'd2, 5'd3, 5'd4};
    idxs = '{3'd2, 3'd4, 3'd6, 3'd5};
    exp_fs = '{10'd0, 10'd1000, 10'd976, 10'd952};
    sweep("wrap", 10'd1000);
    check_peak("wrap", 5'd4, 3'd5, 2'd3);
    release_done("wrap");

    // Reset mid-sweep after the second accept.
    step_size = 10'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_axis_tvalid = 1'b1;
      out_max = 5'(7 + k);
      index = 3'(k + 1);
      tick();
      m_axis_tvalid = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fs", 32'(freq_step), 32'd0);
    chk("mid_rst_fsv", 32'(freq_step_valid), 32'd0);
    chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("mid_rst_tvalid", 32'(s_axis_tvalid), 32'd0);
    check_peak("mid_rst", 5'd0, 3'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    m_axis_tvalid = 1'b1;
    out_max = 5'd20;
    index = 3'd3;
    tick();
    tick();
    m_axis_tvalid = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_tvalid", 32'(s_axis_tvalid), 32'd0);
    check_peak("post_rst", 5'd0, 3'd0, 2'd0);

    vals = '{5'd11, 5'd2, 5'd12, 5'd12};
    idxs = '{3'd6, 3'd1, 3'd4, 3'd2};
    exp_fs = '{10'd0, 10'd5, 10'd10, 10'd15};
    sweep("clean", 10'd5);
    check_peak("clean", 5'd12, 3'd4, 2'd2);
    release_done("clean");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
